// File: rtl/program_counter_stack.sv
// -----------------------------------------------------------------------------
// program_counter_stack
//
// Program counter for the SAP-style datapath with an internal return-address
// stack. It holds the address of the next instruction, increments on request,
// loads jump targets from the shared bus, and performs single-cycle CALL/RET
// by pushing and popping return addresses internally.
//
// All state updates happen on the falling edge of clk. The sequencer sets the
// control inputs up on the rising edge, so there is half a cycle of setup.
//
// Ports
//   clk          clock; state updates on the falling edge
//   reset        synchronous active-high reset, sampled on the falling edge
//   ie           load data from bus (jump)
//   oe           drive data onto bus (combinational, independent of reset)
//   step         increment data (wraps modulo 2^WIDTH)
//   call         push data onto the return stack, load data from bus
//   ret          pop the top of the return stack into data
//   data         current program counter (registered)
//   bus          shared tri-state system bus
//   depth        number of valid return-stack entries
//   stack_full   depth == DEPTH
//   stack_empty  depth == 0
//   err          sticky stack fault flag, cleared only by reset
// -----------------------------------------------------------------------------
module program_counter_stack #(
  parameter int               WIDTH        = 8,
  parameter int               DEPTH        = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ie,
  input  logic                       oe,
  input  logic                       step,
  input  logic                       call,
  input  logic                       ret,
  output logic [WIDTH-1:0]           data,
  inout  wire  [WIDTH-1:0]           bus,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       err
);

  localparam int DW = $clog2(DEPTH + 1);
  // Stack index width; a single-entry stack still needs a 1-bit index.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [DW-1:0]    depth_q;
  logic [DW-1:0]    depth_d;
  logic             err_q;
  logic             err_d;

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];

  logic [IW-1:0]    push_idx;
  logic [IW-1:0]    pop_idx;
  logic             is_full;
  logic             is_empty;
  logic             do_push;

  assign is_full  = (depth_q == DEPTH_MAX);
  assign is_empty = (depth_q == '0);

  // The next free slot is stack[depth]; the top of stack is stack[depth-1].
  // Both indices are only used when the stack is not full / not empty, so
  // truncation to IW bits never aliases a live entry.
  assign push_idx = IW'(depth_q);
  assign pop_idx  = IW'(depth_q - DW'(1));

  // ---------------------------------------------------------------------------
  // Next-state decode. One action per edge with fixed priority:
  // reset > (call & ret) > ret > call > ie > step > hold.
  // Faults only raise err; they never touch data or the stack.
  // ---------------------------------------------------------------------------
  always_comb begin
    data_d  = data_q;
    depth_d = depth_q;
    err_d   = err_q;
    do_push = 1'b0;

    if (reset) begin
      data_d  = RESET_VECTOR;
      depth_d = '0;
      err_d   = 1'b0;
    end else if (call && ret) begin
      err_d = 1'b1;
    end else if (ret) begin
      if (is_empty) begin
        err_d = 1'b1;
      end else begin
        data_d  = stack_q[pop_idx];
        depth_d = depth_q - DW'(1);
      end
    end else if (call) begin
      if (is_full) begin
        err_d = 1'b1;
      end else begin
        // With oe=1 the bus carries data_q itself, so this reloads the
        // current value while still pushing it.
        do_push = 1'b1;
        data_d  = bus;
        depth_d = depth_q + DW'(1);
      end
    end else if (ie) begin
      data_d = bus;
    end else if (step) begin
      data_d = data_q + WIDTH'(1);
    end
  end

  always_comb begin
    stack_d = stack_q;
    if (do_push) begin
      stack_d[push_idx] = data_q;
    end
  end

  always_ff @(negedge clk) begin
    data_q  <= data_d;
    depth_q <= depth_d;
    err_q   <= err_d;
  end

  // Stack contents need no reset: entries above depth are never read.
  always_ff @(negedge clk) begin
    stack_q <= stack_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus         = oe ? data_q : {WIDTH{1'bz}};
  assign data        = data_q;
  assign depth       = depth_q;
  assign err         = err_q;
  assign stack_full  = is_full;
  assign stack_empty = is_empty;

endmodule

// File: tb/tb_program_counter_stack.sv
// -----------------------------------------------------------------------------
// Testbench for program_counter_stack. Directed scenarios plus a randomized
// run checked against a behavioural model (integer PC, queue as return stack,
// sticky error bit). A second instance with RESET_VECTOR=0x30 and DEPTH=2
// checks the reset-vector parameter.
// -----------------------------------------------------------------------------
module tb_program_counter_stack;

  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic ie    = 1'b0;
  logic oe    = 1'b0;
  logic step  = 1'b0;
  logic call  = 1'b0;
  logic ret   = 1'b0;

  logic         tb_drv = 1'b0;
  logic [W-1:0] tb_val = '0;

  wire  [W-1:0] bus;
  wire  [W-1:0] bus2;
  logic [W-1:0] data;
  logic [W-1:0] data2;
  logic [2:0]   depth;
  logic [1:0]   depth2;
  logic         full, empty, err;
  logic         full2, empty2, err2;

  assign bus  = tb_drv ? tb_val : {W{1'bz}};
  assign bus2 = tb_drv ? tb_val : {W{1'bz}};

  program_counter_stack #(.WIDTH(W), .DEPTH(D), .RESET_VECTOR(8'h00)) dut (
    .clk(clk), .reset(reset), .ie(ie), .oe(oe), .step(step), .call(call),
    .ret(ret), .data(data), .bus(bus), .depth(depth), .stack_full(full),
    .stack_empty(empty), .err(err)
  );

  program_counter_stack #(.WIDTH(W), .DEPTH(2), .RESET_VECTOR(8'h30)) dut2 (
    .clk(clk), .reset(reset), .ie(ie), .oe(1'b0), .step(step), .call(call),
    .ret(ret), .data(data2), .bus(bus2), .depth(depth2), .stack_full(full2),
    .stack_empty(empty2), .err(err2)
  );

  int tests = 0;
  int fails = 0;

  // Reference model
  logic [W-1:0] m_pc  = '0;
  logic [W-1:0] m_stk [$];
  logic         m_err = 1'b0;

  // One clock cycle: drive controls after the rising edge, update the model,
  // then return 1 time unit after the falling edge so outputs can be sampled.
  // When drv=0 the bus is assumed self-driven by the DUT (oe=1).
  task automatic apply(input logic r, input logic c, input logic rt,
                       input logic i, input logic s,
                       input logic drv, input logic [W-1:0] v);
    logic [W-1:0] bv;
    @(posedge clk);
    #1;
    reset = r; call = c; ret = rt; ie = i; step = s;
    tb_drv = drv; tb_val = v;
    bv = drv ? v : m_pc;
    if (r) begin
      m_pc = 8'h00;
      m_stk.delete();
      m_err = 1'b0;
    end else if (c && rt) begin
      m_err = 1'b1;
    end else if (rt) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else m_err = 1'b1;
    end else if (c) begin
      if (m_stk.size() < D) begin
        m_stk.push_back(m_pc);
        m_pc = bv;
      end else begin
        m_err = 1'b1;
      end
    end else if (i) begin
      m_pc = bv;
    end else if (s) begin
      m_pc = W'((int'(m_pc) + 1) % 256);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(1, 0, 0, 0, 0, 0, 8'h00);
    apply(1, 0, 0, 0, 0, 0, 8'h00);
    tests++;
    if ({data, depth, full, empty, err} !== {8'h00, 3'd0, 1'b0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got data=%h depth=%0d full=%b empty=%b err=%b, expected 00 0 0 1 0",
               data, depth, full, empty, err);
    end
    tests++;
    if ({data2, depth2, full2, empty2, err2} !== {8'h30, 2'd0, 1'b0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_vector: got data=%h depth=%0d full=%b empty=%b err=%b, expected 30 0 0 1 0",
               data2, depth2, full2, empty2, err2);
    end
    apply(0, 0, 0, 0, 0, 1, 8'h5C);
    tests++;
    if (bus !== 8'h5C) begin
      fails++;
      $display("FAIL reset_bus_released: got bus=%h expected 5c", bus);
    end
  endtask

  task automatic test_step_hold_oe();
    logic [W-1:0] exp_v;
    apply(1, 0, 0, 0, 0, 0, 8'h00);
    for (int k = 1; k <= 3; k++) begin
      apply(0, 0, 0, 0, 1, 0, 8'h00);
      exp_v = W'(k);
      tests++;
      if (data !== exp_v) begin
        fails++;
        $display("FAIL step_%0d: got data=%h expected %h", k, data, exp_v);
      end
    end
    apply(0, 0, 0, 0, 0, 0, 8'h00);
    apply(0, 0, 0, 0, 0, 0, 8'h00);
    tests++;
    if (data !== 8'h03) begin
      fails++;
      $display("FAIL hold: got data=%h expected 03", data);
    end
    oe = 1'b1;
    #1;
    tests++;
    if (bus !== 8'h03) begin
      fails++;
      $display("FAIL oe_drive: got bus=%h expected 03", bus);
    end
    oe = 1'b0;
    tb_drv = 1'b1; tb_val = 8'h5C;
    #1;
    tests++;
    if (bus !== 8'h5C) begin
      fails++;
      $display("FAIL oe_release: got bus=%h expected 5c", bus);
    end
    tb_drv = 1'b0;
  endtask

  task automatic test_wrap_and_load();
    apply(0, 0, 0, 1, 0, 1, 8'hFE);
    apply(0, 0, 0, 0, 1, 0, 8'h00);
    tests++;
    if (data !== 8'hFF) begin
      fails++;
      $display("FAIL wrap_ff: got data=%h expected ff", data);
    end
    apply(0, 0, 0, 0, 1, 0, 8'h00);
    tests++;
    if ({data, err} !== {8'h00, 1'b0}) begin
      fails++;
      $display("FAIL wrap_00: got data=%h err=%b expected 00 0", data, err);
    end
    apply(0, 0, 0, 1, 1, 1, 8'h40);
    tests++;
    if (data !== 8'h40) begin
      fails++;
      $display("FAIL load_beats_step: got data=%h expected 40", data);
    end
  endtask

  task automatic test_call_ret();
    apply(1, 0, 0, 0, 0, 0, 8'h00);
    apply(0, 0, 0, 1, 0, 1, 8'h10);
    apply(0, 1, 0, 0, 0, 1, 8'h80);
    tests++;
    if ({data, depth, empty} !== {8'h80, 3'd1, 1'b0}) begin
      fails++;
      $display("FAIL call: got data=%h depth=%0d empty=%b expected 80 1 0", data, depth, empty);
    end
    apply(0, 0, 0, 0, 1, 0, 8'h00);
    tests++;
    if (data !== 8'h81) begin
      fails++;
      $display("FAIL step_in_sub: got data=%h expected 81", data);
    end
    apply(0, 0, 1, 0, 0, 0, 8'h00);
    tests++;
    if ({data, depth, empty, err} !== {8'h10, 3'd0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL ret: got data=%h depth=%0d empty=%b err=%b expected 10 0 1 0",
               data, depth, empty, err);
    end
  endtask

  task automatic test_nested_overflow();
    logic [W-1:0] exp_v;
    apply(1, 0, 0, 0, 0, 0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      apply(0, 0, 0, 1, 0, 1, W'(k + 1));
      apply(0, 1, 0, 0, 0, 1, W'(8'h20 + k));
    end
    tests++;
    if ({data, depth, full, err} !== {8'h23, 3'd4, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL nested_full: got data=%h depth=%0d full=%b err=%b expected 23 4 1 0",
               data, depth, full, err);
    end
    apply(0, 1, 0, 0, 0, 1, 8'h99);
    tests++;
    if ({data, depth, err} !== {8'h23, 3'd4, 1'b1}) begin
      fails++;
      $display("FAIL overflow: got data=%h depth=%0d err=%b expected 23 4 1", data, depth, err);
    end
    for (int k = 4; k >= 1; k--) begin
      apply(0, 0, 1, 0, 0, 0, 8'h00);
      exp_v = W'(k);
      tests++;
      if ({data, depth} !== {exp_v, 3'(k - 1)}) begin
        fails++;
        $display("FAIL unwind_%0d: got data=%h depth=%0d expected %h %0d", k, data, depth, exp_v, k - 1);
      end
    end
  endtask

  task automatic test_faults();
    apply(1, 0, 0, 0, 0, 0, 8'h00);
    apply(0, 0, 0, 1, 0, 1, 8'h77);
    apply(0, 0, 1, 0, 0, 0, 8'h00);
    tests++;
    if ({data, depth, err} !== {8'h77, 3'd0, 1'b1}) begin
      fails++;
      $display("FAIL underflow: got data=%h depth=%0d err=%b expected 77 0 1", data, depth, err);
    end
    apply(1, 0, 0, 0, 0, 0, 8'h00);
    apply(0, 0, 0, 1, 0, 1, 8'h05);
    apply(0, 1, 0, 0, 0, 1, 8'h60);
    apply(0, 1, 1, 0, 0, 1, 8'hAA);
    tests++;
    if ({data, depth, err} !== {8'h60, 3'd1, 1'b1}) begin
      fails++;
      $display("FAIL call_and_ret: got data=%h depth=%0d err=%b expected 60 1 1", data, depth, err);
    end
    apply(0, 0, 0, 0, 1, 0, 8'h00);
    apply(0, 0, 1, 0, 0, 0, 8'h00);
    tests++;
    if ({data, depth, err} !== {8'h05, 3'd0, 1'b1}) begin
      fails++;
      $display("FAIL err_sticky: got data=%h depth=%0d err=%b expected 05 0 1", data, depth, err);
    end
    apply(1, 0, 0, 0, 0, 0, 8'h00);
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_clear: got err=%b expected 0", err);
    end
  endtask

  task automatic test_reset_mid_call();
    apply(1, 0, 0, 0, 0, 0, 8'h00);
    apply(0, 0, 0, 1, 0, 1, 8'h11);
    apply(0, 1, 0, 0, 0, 1, 8'h22);
    apply(0, 1, 0, 0, 0, 1, 8'h33);
    apply(1, 1, 0, 0, 0, 1, 8'h55);
    tests++;
    if ({data, depth, empty, err} !== {8'h00, 3'd0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_with_call: got data=%h depth=%0d empty=%b err=%b expected 00 0 1 0",
               data, depth, empty, err);
    end
    tests++;
    if ({data2, depth2} !== {8'h30, 2'd0}) begin
      fails++;
      $display("FAIL reset_with_call_vec: got data=%h depth=%0d expected 30 0", data2, depth2);
    end
  endtask

  task automatic test_self_load();
    apply(0, 0, 0, 1, 0, 1, 8'h42);
    oe = 1'b1;
    apply(0, 0, 0, 1, 0, 0, 8'h00);
    apply(0, 1, 0, 0, 0, 0, 8'h00);
    tests++;
    if ({data, depth, err} !== {8'h42, 3'd1, 1'b0}) begin
      fails++;
      $display("FAIL self_load_call: got data=%h depth=%0d err=%b expected 42 1 0", data, depth, err);
    end
    oe = 1'b0;
    apply(0, 0, 0, 0, 1, 0, 8'h00);
    apply(0, 0, 1, 0, 0, 0, 8'h00);
    tests++;
    if ({data, depth} !== {8'h42, 3'd0}) begin
      fails++;
      $display("FAIL self_load_ret: got data=%h depth=%0d expected 42 0", data, depth);
    end
  endtask

  task automatic test_random();
    int k;
    logic r, c, rt, i, s, o;
    apply(1, 0, 0, 0, 0, 0, 8'h00);
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(0, 99) < 3);
      k  = $urandom_range(0, 19);
      c  = (k < 6) || (k == 12);
      rt = (k >= 6 && k < 11) || (k == 12);
      i  = ($urandom_range(0, 3) == 0);
      s  = ($urandom_range(0, 1) == 1);
      o  = ($urandom_range(0, 3) == 0);
      oe = o;
      apply(r, c, rt, i, s, !o, W'($urandom_range(0, 255)));
      tests++;
      if ({data, depth, full, empty, err} !==
          {m_pc, 3'(m_stk.size()), m_stk.size() == D, m_stk.size() == 0, m_err}) begin
        fails++;
        $display("FAIL random_%0d: got data=%h depth=%0d full=%b empty=%b err=%b expected %h %0d %b %b %b",
                 n, data, depth, full, empty, err, m_pc, m_stk.size(),
                 m_stk.size() == D, m_stk.size() == 0, m_err);
      end
    end
    oe = 1'b0;
  endtask

  initial begin
    test_reset();
    test_step_hold_oe();
    test_wrap_and_load();
    test_call_ret();
    test_nested_overflow();
    test_faults();
    test_reset_mid_call();
    test_self_load();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
